demux8_reg: RTL

Registered 1-to-8 byte distributor for the Mini 8-bit CPU datapath. It is the write-side counterpart of the 8-to-1 byte selector: one 8-bit input is steered into one of eight 8-bit holding registers A..H. The select lines S1,S2,S3 use the same encoding as the selector, so `{S1,S2,S3}=3'b000` addresses A and `3'b111` addresses H. Each slot carries a per-slot "loaded" flag with a consumer acknowledge, an optional auto-increment write pointer, and a sticky overwrite flag.

---
 rtl/demux8_reg.sv | 90 +++++++++
 1 files changed

// File: rtl/demux8_reg.sv
// Registered 1-to-8 byte distributor: steers D into one of eight holding slots with loaded flags.
// Latency 1 cycle for write/ack; no stall, producer throttles on full/loaded.
module demux8_reg (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] D,
    input  logic       S1,
    input  logic       S2,
    input  logic       S3,
    input  logic       wr_en,
    input  logic       auto_inc,
    input  logic       ptr_clr,
    input  logic       ack,
    input  logic [2:0] ack_sel,
    output logic [7:0] A,
    output logic [7:0] B,
    output logic [7:0] C,
    output logic [7:0] D_o,
    output logic [7:0] E,
    output logic [7:0] F,
    output logic [7:0] G,
    output logic [7:0] H,
    output logic [7:0] loaded,
    output logic       full,
    output logic [2:0] ptr,
    output logic       ovf
);

    logic [7:0] slot_q [8];
    logic [7:0] slot_d [8];
    logic [7:0] loaded_q, loaded_d;
    logic [2:0] ptr_q, ptr_d;
    logic       ovf_q, ovf_d;
    logic [2:0] waddr;
    logic       ovf_set;

    assign waddr   = auto_inc ? ptr_q : {S1, S2, S3};
    assign ovf_set = wr_en && loaded_q[waddr];

    always_comb begin
        slot_d   = slot_q;
        loaded_d = loaded_q;
        ptr_d    = ptr_q;
        ovf_d    = ovf_q;
        // Ack is applied first so a same-slot write overrides it.
        if (ack)
            loaded_d[ack_sel] = 1'b0;
        if (wr_en) begin
            slot_d[waddr]   = D;
            loaded_d[waddr] = 1'b1;
        end
        if (ptr_clr)
            ptr_d = 3'd0;
        else if (wr_en && auto_inc)
            ptr_d = ptr_q + 3'd1;
        if (ovf_set)
            ovf_d = 1'b1;
        else if (ptr_clr)
            ovf_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++)
                slot_q[i] <= 8'h00;
            loaded_q <= 8'h00;
            ptr_q    <= 3'd0;
            ovf_q    <= 1'b0;
        end else begin
            slot_q   <= slot_d;
            loaded_q <= loaded_d;
            ptr_q    <= ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    assign A      = slot_q[0];
    assign B      = slot_q[1];
    assign C      = slot_q[2];
    assign D_o    = slot_q[3];
    assign E      = slot_q[4];
    assign F      = slot_q[5];
    assign G      = slot_q[6];
    assign H      = slot_q[7];
    assign loaded = loaded_q;
    assign full   = &loaded_q;
    assign ptr    = ptr_q;
    assign ovf    = ovf_q;

endmodule
